// File: rtl/rsa_operand_packer.sv
// Packs a stream of IN_W-bit words little-endian into one OUT_W-bit operand
// and presents it on a valid/ready handshake, tracking which of 5 operands is loaded.
`timescale 1ns/1ps
module rsa_operand_packer #(
  parameter int OUT_W = 1024,
  parameter int IN_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sync_clr,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_short,
  output logic [2:0]       operand_idx
);

  localparam int N_WORDS = OUT_W / IN_W;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);
  localparam logic [2:0]       LAST_IDX = 3'd4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   buf_q, buf_d;
  logic [2:0]         idx_q, idx_d;
  logic               short_q, short_d;

  // Handshake outputs decode only registered state, so neither depends
  // combinationally on s_valid or m_ready.
  assign s_ready     = (state_q == FILL);
  assign m_valid     = (state_q == HOLD);
  assign m_data      = buf_q;
  assign m_short     = short_q;
  assign operand_idx = idx_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    short_d = short_q;

    if (sync_clr) begin
      state_d = FILL;
      cnt_d   = '0;
      buf_d   = '0;
      idx_d   = '0;
      short_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid && s_ready) begin
            buf_d[int'(cnt_q)*IN_W +: IN_W] = s_data;
            if (s_last || (cnt_q == LAST_CNT)) begin
              state_d = HOLD;
              cnt_d   = '0;
              short_d = (cnt_q != LAST_CNT);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (m_valid && m_ready) begin
            state_d = FILL;
            // Clearing here makes the unfilled words of a short operand read as zero.
            buf_d   = '0;
            short_d = 1'b0;
            idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: the operand buffer is a plain register bank, not a RAM, so it is
  // reset along with the control state; a short operand relies on it being zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
      short_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      short_q <= short_d;
    end
  end

endmodule

// File: tb/tb_rsa_operand_packer.sv
// Directed self-checking bench for rsa_operand_packer with default parameters
// (32 words of 32 bits per operand).
`timescale 1ns/1ps
module tb_rsa_operand_packer;

  logic          clk = 1'b0;
  logic          resetn;
  logic          sync_clr;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [1023:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_short;
  logic [2:0]    operand_idx;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_w [32];

  rsa_operand_packer #(.OUT_W(1024), .IN_W(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sync_clr    (sync_clr),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_short     (m_short),
    .operand_idx (operand_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected operand: words 0..n-1 are base+i, the rest zero.
  task automatic set_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < 32; i++) exp_w[i] = (i < n) ? base + 32'(i) : 32'h0;
  endtask

  task automatic check_data(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_w%0d", tag, i), {32'h0, m_data[i*32 +: 32]}, {32'h0, exp_w[i]});
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {63'h0, s_ready}, 64'h1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_operand(input logic [31:0] base, input int n, input logic use_last,
                              input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      send_word(base + 32'(i), use_last && (i == n - 1));
    end
  endtask

  // One-cycle output handshake starting from a HOLD state.
  task automatic handshake();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    sync_clr = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    m_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_valid", {63'h0, m_valid}, 64'h0);
    check("rst_m_short", {63'h0, m_short}, 64'h0);
    check("rst_idx", {61'h0, operand_idx}, 64'h0);
    set_exp(32'h0, 0);
    check_data("rst_data");
    resetn = 1'b1;
    @(negedge clk);
    check("rst_s_ready", {63'h0, s_ready}, 64'h1);

    // 1. Full operand with m_ready held high
    m_ready = 1'b1;
    send_operand(32'h0, 32, 1'b0, 0);
    check("t1_m_valid", {63'h0, m_valid}, 64'h1);
    check("t1_m_short", {63'h0, m_short}, 64'h0);
    check("t1_idx", {61'h0, operand_idx}, 64'h0);
    set_exp(32'h0, 32);
    check_data("t1_data");
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("t1_post_m_valid", {63'h0, m_valid}, 64'h0);
    check("t1_post_s_ready", {63'h0, s_ready}, 64'h1);
    check("t1_post_idx", {61'h0, operand_idx}, 64'h1);
    set_exp(32'h0, 0);
    check_data("t1_cleared");

    // 2. Backpressure for 10 cycles, then exactly one transfer
    send_operand(32'h1000, 32, 1'b1, 0);
    set_exp(32'h1000, 32);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t2_bp_s_ready", {63'h0, s_ready}, 64'h0);
      check("t2_bp_m_valid", {63'h0, m_valid}, 64'h1);
      check("t2_bp_m_short", {63'h0, m_short}, 64'h0);
      check("t2_bp_idx", {61'h0, operand_idx}, 64'h1);
      check_data("t2_bp_data");
    end
    handshake();
    check("t2_post_m_valid", {63'h0, m_valid}, 64'h0);
    check("t2_post_idx", {61'h0, operand_idx}, 64'h2);
    @(negedge clk);
    check("t2_next_s_ready", {63'h0, s_ready}, 64'h1);
    check("t2_next_idx", {61'h0, operand_idx}, 64'h2);

    // 3. Short operand of three words, then a full one with no residue
    send_word(32'hAAAA_0001, 1'b0);
    send_word(32'hAAAA_0002, 1'b0);
    send_word(32'hBBBB_0003, 1'b1);
    check("t3_m_valid", {63'h0, m_valid}, 64'h1);
    check("t3_m_short", {63'h0, m_short}, 64'h1);
    check("t3_idx", {61'h0, operand_idx}, 64'h2);
    set_exp(32'h0, 0);
    exp_w[0] = 32'hAAAA_0001;
    exp_w[1] = 32'hAAAA_0002;
    exp_w[2] = 32'hBBBB_0003;
    check_data("t3_short_data");
    handshake();
    send_operand(32'hC000_0000, 32, 1'b0, 0);
    check("t3_full_m_short", {63'h0, m_short}, 64'h0);
    check("t3_full_idx", {61'h0, operand_idx}, 64'h3);
    set_exp(32'hC000_0000, 32);
    check_data("t3_full_data");
    handshake();
    check("t3_post_idx", {61'h0, operand_idx}, 64'h4);

    // sync_clr while idle in FILL returns the index to operand 0
    @(negedge clk);
    sync_clr = 1'b1;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    check("clr_fill_idx", {61'h0, operand_idx}, 64'h0);

    // 4. Six 4-word operands with random gaps: index 0,1,2,3,4,0
    for (int k = 0; k < 6; k++) begin
      logic [2:0] exp_idx;
      exp_idx = (k == 5) ? 3'd0 : 3'(k);
      send_word(32'h4000_0000 + 32'(k * 256), 1'b0);
      check($sformatf("t4_op%0d_idx_first", k), {61'h0, operand_idx}, {61'h0, exp_idx});
      for (int i = 1; i < 4; i++) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
        send_word(32'h4000_0000 + 32'(k * 256 + i), i == 3);
      end
      check($sformatf("t4_op%0d_m_valid", k), {63'h0, m_valid}, 64'h1);
      check($sformatf("t4_op%0d_m_short", k), {63'h0, m_short}, 64'h1);
      check($sformatf("t4_op%0d_idx_hold", k), {61'h0, operand_idx}, {61'h0, exp_idx});
      set_exp(32'h4000_0000 + 32'(k * 256), 4);
      check_data($sformatf("t4_op%0d", k));
      handshake();
    end
    check("t4_post_idx", {61'h0, operand_idx}, 64'h1);

    // 5. Asynchronous reset after 17 words, between edges
    send_operand(32'h5000_0000, 17, 1'b0, 0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_rst_m_valid", {63'h0, m_valid}, 64'h0);
    check("t5_rst_idx", {61'h0, operand_idx}, 64'h0);
    set_exp(32'h0, 0);
    check_data("t5_rst_data");
    @(negedge clk);
    #2;
    resetn = 1'b1;
    send_operand(32'hD000_0000, 32, 1'b0, 0);
    check("t5_m_valid", {63'h0, m_valid}, 64'h1);
    check("t5_m_short", {63'h0, m_short}, 64'h0);
    check("t5_idx", {61'h0, operand_idx}, 64'h0);
    set_exp(32'hD000_0000, 32);
    check_data("t5_data");
    handshake();
    check("t5_post_idx", {61'h0, operand_idx}, 64'h1);

    // 6. One-word operand, then sync_clr in HOLD with m_ready high
    send_word(32'hE1E2_E3E4, 1'b1);
    check("t6_one_m_valid", {63'h0, m_valid}, 64'h1);
    check("t6_one_m_short", {63'h0, m_short}, 64'h1);
    check("t6_one_idx", {61'h0, operand_idx}, 64'h1);
    set_exp(32'h0, 0);
    exp_w[0] = 32'hE1E2_E3E4;
    check_data("t6_one_data");
    @(negedge clk);
    sync_clr = 1'b1;
    m_ready  = 1'b1;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    m_ready  = 1'b0;
    check("t6_clr_m_valid", {63'h0, m_valid}, 64'h0);
    check("t6_clr_s_ready", {63'h0, s_ready}, 64'h1);
    check("t6_clr_m_short", {63'h0, m_short}, 64'h0);
    check("t6_clr_idx", {61'h0, operand_idx}, 64'h0);
    set_exp(32'h0, 0);
    check_data("t6_clr_data");
    @(negedge clk);
    check("t6_clr_idx_stable", {61'h0, operand_idx}, 64'h0);
    send_operand(32'hF000_0000, 2, 1'b1, 0);
    check("t6_after_m_short", {63'h0, m_short}, 64'h1);
    check("t6_after_idx", {61'h0, operand_idx}, 64'h0);
    set_exp(32'hF000_0000, 2);
    check_data("t6_after_data");
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_operand_packer.md
# rsa_operand_packer

Upstream feeder for the RSA wrapper's 1024-bit operand port. It accepts a stream of narrow words from the ARM-side bus and assembles them into one full-width operand. It presents each operand on a valid/ready handshake that matches `arm_to_fpga_data` / `arm_to_fpga_data_valid` / `arm_to_fpga_data_ready`. It also tracks which of the five operands is being loaded (msg, exp, n, rmodn, r2modn), so software and debug logic can see the load sequence.

## Interface
Parameters:
- `OUT_W`, default 1024: operand width; must be an integer multiple of `IN_W`.
- `IN_W`, default 32: input word width.
- `N_WORDS` (localparam) = `OUT_W/IN_W`, 32 by default: words per operand.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `sync_clr`  in  1: synchronous clear of the whole block; overrides every other input.
- `s_data`  in  IN_W: input word.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: this word is the last word of the current operand.
- `s_ready`  out  1: block can accept a word.
- `m_data`  out  OUT_W: assembled operand.
- `m_valid`  out  1: `m_data` holds a complete operand.
- `m_ready`  in  1: downstream accepts the operand.
- `m_short`  out  1: the operand was terminated by `s_last` before `N_WORDS` words; qualified by `m_valid`.
- `operand_idx`  out  3: index of the operand being filled or held, 0..4.

## Operation
- Two states: FILL and HOLD.
- **Reset (`resetn`=0, asynchronous):**
  - state = FILL, word counter = 0, buffer = 0, `operand_idx` = 0.
  - `m_valid` = 0, `m_short` = 0, `s_ready` = 1 once reset is released.
- **FILL:**
  - `s_ready` = 1.
  - Accept a word on `s_valid`&&`s_ready`: write `s_data` to buffer bits [cnt*IN_W +: IN_W] and increment cnt.
  - Packing is little-endian: the first word lands in bits [IN_W-1:0].
  - Leave FILL when the accepted word has cnt==`N_WORDS`-1 or `s_last`=1: go to HOLD, set `m_valid`=1, reset cnt to 0.
  - `m_short` = 1 iff `s_last` was seen with cnt<`N_WORDS`-1.
  - `s_last` on word `N_WORDS`-1 is normal (`m_short`=0). Having no `s_last` on that word is also legal.
- **HOLD:**
  - `s_ready` = 0 and `m_data` is stable.
  - On `m_valid`&&`m_ready`: go to FILL, clear buffer to 0, clear `m_valid` and `m_short`.
  - Same event: `operand_idx` increments, wrapping 4 -> 0.
  - Because the buffer is cleared on each new operand, unfilled upper words of a short operand read as zero.
- **`sync_clr`=1:** on the next edge, same state as reset. Any word or handshake in that cycle is discarded and `operand_idx` is not incremented.
- There is no error state. `s_valid` while `s_ready`=0 is held off by the handshake; the block never drops a word.

## Timing
- `s_ready` and `m_valid` are registered decodes of the state; neither combinationally depends on `s_valid` or `m_ready`.
- **Latency:** the last word is accepted at edge E. From E, `m_valid`=1 and `m_data` is complete. There is no extra pipeline cycle.
- **Throughput:**
  - One word per cycle during FILL.
  - Minimum `N_WORDS`+1 cycles per operand: `N_WORDS` accept cycles plus one HOLD cycle with `m_ready`=1.
  - First word of the next operand is accepted no earlier than the cycle after the output handshake.
- **Backpressure:** with `m_ready`=0, HOLD lasts indefinitely. `m_data`, `m_short` and `operand_idx` stay constant.
- **Handshake rule:** once `m_valid` is raised it stays high until the transfer completes.
- **Reset mid-operation:** partially filled data is discarded. After release, the next accepted word goes to bits [IN_W-1:0] of operand 0.
- **`s_last` on the first word:** a one-word operand, with `m_short`=1 and bits above IN_W equal to 0.

## Test plan
1. **Full operand:** send 32 words 0x00000000..0x0000001F with `s_valid` held high and `m_ready`=1. Expect `m_valid` on the edge of word 31, `m_data` word i == i, `m_short`=0, and `operand_idx` 0 -> 1 after the handshake.
2. **Backpressure:** hold `m_ready`=0 for 10 cycles after the operand completes. Expect `s_ready`=0 and `m_data` unchanged throughout. Raise `m_ready`: expect exactly one transfer, then `s_ready`=1 on the next cycle.
3. **Short operand:** send 3 words 0xAAAA0001, 0xAAAA0002, 0xBBBB0003, with `s_last` on the third. Expect `m_short`=1, bits [95:0] = those words, bits [1023:96] = 0. The next full operand must show no residue.
4. **Index wrap:** load 6 operands back-to-back with random `s_valid` gaps. Expect `operand_idx` sequence 0,1,2,3,4,0, each value stable from the first word of its operand through its output handshake.
5. **Asynchronous reset mid-fill:** drop `resetn` after 17 words, between clock edges. Expect `m_valid`=0 immediately and `operand_idx`=0. After release, a full operand equals only the new words.
6. **`sync_clr` in HOLD:** with `m_ready`=1 in the same cycle, expect no transfer counted, `operand_idx`=0, FILL entered, and buffer zero.
